uart_rx: RTL

//  UART serial receiver; the consumer of the oversampling tick from the baud-rate generator.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB-first, one-clk done strobe.
// Optional parity stage is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err
);

    // The tick counter widens only when the stop period exceeds one bit time.
    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
    localparam logic          PARITY_SENSE = 1'(PARITY_ODD);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]      state;
    logic [SW-1:0]   s;
    logic [2:0]      n;
    logic [DBIT-1:0] b;
`ifdef UART_RX_PARITY_EN
    logic            p_bit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
`ifdef UART_RX_PARITY_EN
            p_bit        <= 1'b0;
`endif
            rx_done_tick <= 1'b0;
            dout         <= '0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_MID) begin
                            if (!rx) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= {rx, b[DBIT-1:1]};
                            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            p_bit <= rx;
                            state <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            state        <= IDLE;
                            rx_done_tick <= 1'b1;
                            dout         <= b;
                            frame_err    <= ~rx;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= ((^b) ^ p_bit) != PARITY_SENSE;
`else
                            // The sense is meaningless without a parity stage; the flag stays low.
                            parity_err   <= PARITY_SENSE & 1'b0;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
